scv_cart: RTL and testbench

//  Cartridge slot model for the Super Cassette Vision: 128 KiB ROM image loaded at init

---
 rtl/scv_pkg.sv | 19 +
 rtl/dpram.sv | 31 +++
 rtl/scv_cart.sv | 105 ++++++++++
 tb/tb_scv_cart.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/scv_pkg.sv
// Shared types for the Super Cassette Vision cartridge slot: cartridge mapper codes
// and the fixed geometry of the ROM image and battery RAM.
package scv_pkg;

    typedef enum logic [2:0] {
        MAPPER_ROM8K       = 3'd0,
        MAPPER_ROM16K      = 3'd1,
        MAPPER_ROM32K      = 3'd2,
        MAPPER_ROM32K_RAM  = 3'd3,
        MAPPER_ROM64K      = 3'd4,
        MAPPER_ROM128K     = 3'd5,
        MAPPER_ROM128K_RAM = 3'd6
    } mapper_t;

    localparam int SCV_ROM_AW = 17;
    localparam int SCV_RAM_AW = 13;
    localparam int SCV_DW     = 8;

endpackage

// File: rtl/dpram.sv
// Dual-port block RAM: port 1 has independent write and registered read addresses,
// port 2 is a write-only side port. Reads return the pre-write contents (read-first).
module dpram #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_waddr,
    input  logic [DW-1:0] p1_wdata,
    input  logic [AW-1:0] p1_raddr,
    output logic [DW-1:0] p1_rdata,
    input  logic          p2_we,
    input  logic [AW-1:0] p2_addr,
    input  logic [DW-1:0] p2_wdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Contents are never reset: ROM image and battery RAM survive RESET.
    always_ff @(posedge clk) begin
        if (p1_we) begin
            mem[p1_waddr] <= p1_wdata;
        end
        if (p2_we) begin
            mem[p2_addr] <= p2_wdata;
        end
        p1_rdata <= mem[p1_raddr];
    end

endmodule

// File: rtl/scv_cart.sv
// Super Cassette Vision cartridge slot: ROM image plus optional battery RAM decoded into
// the CPU window 0x8000-0xFFFF according to the cartridge mapper and port C bits 6:5.
module scv_cart
    import scv_pkg::*;
#(
    parameter int ROM_AW = SCV_ROM_AW,
    parameter int RAM_AW = SCV_RAM_AW
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              INIT_SEL,
    input  logic [ROM_AW-1:0] INIT_ADDR,
    input  logic [7:0]        INIT_DATA,
    input  logic              INIT_VALID,
    input  mapper_t           MAPPER,
    input  logic [14:0]       A,
    input  logic [7:0]        DB_I,
    output logic [7:0]        DB_O,
    output logic              DB_OE,
    input  logic              CSB,
    input  logic              RDB,
    input  logic              WRB,
    input  logic [1:0]        PC
);

    logic [ROM_AW-1:0] rom_addr;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_hit;
    logic              ram_we;
    logic              rom_we;
    logic [7:0]        rom_q;
    logic [7:0]        ram_q;
    logic              sel_ram_reg;
    logic              clear_reg;

    // Bank and RAM enable follow PC combinationally; nothing is latched from port C.
    always_comb begin
        rom_addr = {2'b00, A};
        ram_addr = A[12:0];
        ram_hit  = 1'b0;
        case (MAPPER)
            MAPPER_ROM8K:  rom_addr = {4'b0000, A[12:0]};
            MAPPER_ROM16K: rom_addr = {3'b000, A[13:0]};
            MAPPER_ROM32K_RAM: begin
                ram_hit = PC[0] && (A[14:13] == 2'b11);
            end
            MAPPER_ROM64K:  rom_addr = {1'b0, PC[0], A};
            MAPPER_ROM128K: rom_addr = {PC[1], PC[0], A};
            MAPPER_ROM128K_RAM: begin
                rom_addr = {PC[1], PC[0], A};
                ram_hit  = (A[14:12] == 3'b111);
                ram_addr = {1'b0, A[11:0]};
            end
            default: ;
        endcase
    end

    assign rom_we = INIT_SEL & INIT_VALID;
    assign ram_we = ~CSB & ~WRB & ram_hit;
    assign DB_OE  = ~CSB & ~RDB;

    dpram #(
        .AW (ROM_AW),
        .DW (8)
    ) u_rom (
        .clk      (CLK),
        .p1_we    (rom_we),
        .p1_waddr (INIT_ADDR),
        .p1_wdata (INIT_DATA),
        .p1_raddr (rom_addr),
        .p1_rdata (rom_q),
        .p2_we    (1'b0),
        .p2_addr  ({ROM_AW{1'b0}}),
        .p2_wdata (8'h00)
    );

    dpram #(
        .AW (RAM_AW),
        .DW (8)
    ) u_ram (
        .clk      (CLK),
        .p1_we    (ram_we),
        .p1_waddr (ram_addr),
        .p1_wdata (DB_I),
        .p1_raddr (ram_addr),
        .p1_rdata (ram_q),
        .p2_we    (1'b0),
        .p2_addr  ({RAM_AW{1'b0}}),
        .p2_wdata (8'h00)
    );

    // Source select is captured alongside the memory read so DB_O stays a registered value.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clear_reg   <= 1'b1;
            sel_ram_reg <= 1'b0;
        end else begin
            clear_reg   <= 1'b0;
            sel_ram_reg <= ram_hit;
        end
    end

    assign DB_O = clear_reg ? 8'h00 : (sel_ram_reg ? ram_q : rom_q);

endmodule

// File: tb/tb_scv_cart.sv
// Scoreboard bench for scv_cart: reads push expected bytes, a monitor pops and compares
// whenever the cartridge drives the data bus.
module tb_scv_cart;
    import scv_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        INIT_SEL = 1'b0;
    logic [16:0] INIT_ADDR = '0;
    logic [7:0]  INIT_DATA = '0;
    logic        INIT_VALID = 1'b0;
    mapper_t     MAPPER = MAPPER_ROM8K;
    logic [14:0] A = '0;
    logic [7:0]  DB_I = '0;
    logic [7:0]  DB_O;
    logic        DB_OE;
    logic        CSB = 1'b1;
    logic        RDB = 1'b1;
    logic        WRB = 1'b1;
    logic [1:0]  PC = 2'b00;

    int checks = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];

    scv_cart dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .INIT_SEL   (INIT_SEL),
        .INIT_ADDR  (INIT_ADDR),
        .INIT_DATA  (INIT_DATA),
        .INIT_VALID (INIT_VALID),
        .MAPPER     (MAPPER),
        .A          (A),
        .DB_I       (DB_I),
        .DB_O       (DB_O),
        .DB_OE      (DB_OE),
        .CSB        (CSB),
        .RDB        (RDB),
        .WRB        (WRB),
        .PC         (PC)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] romv(input logic [16:0] i);
        return i[7:0] ^ i[15:8] ^ {7'b0, i[16]};
    endfunction

    task automatic load(input logic [16:0] addr, input logic [7:0] data, input logic sel);
        @(negedge CLK);
        INIT_SEL = sel; INIT_VALID = 1'b1; INIT_ADDR = addr; INIT_DATA = data;
        @(negedge CLK);
        INIT_SEL = 1'b0; INIT_VALID = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [14:0] a, input logic [7:0] exp);
        @(negedge CLK);
        A = a; CSB = 1'b0; RDB = 1'b0; WRB = 1'b1;
        exp_q.push_back(exp); name_q.push_back(nm);
        @(negedge CLK);
        RDB = 1'b1; CSB = 1'b1;
        $display("read  %-14s A=%04h PC=%b MAPPER=%0d expect %02h", nm, a, PC, MAPPER, exp);
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d);
        @(negedge CLK);
        A = a; DB_I = d; CSB = 1'b0; WRB = 1'b0; RDB = 1'b1;
        @(negedge CLK);
        WRB = 1'b1; CSB = 1'b1;
        $display("write A=%04h PC=%b MAPPER=%0d data %02h", a, PC, MAPPER, d);
    endtask

    // Monitor: one comparison per bus-drive cycle, sampled away from the clock edge.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (DB_OE) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_drive: DB_O=%02h with no pending read", DB_O);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    automatic string n = name_q.pop_front();
                    if (DB_O !== e) begin
                        fails++;
                        $display("FAIL %s: got %02h expected %02h", n, DB_O, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [16:0] addrs [12];
        addrs = '{17'h00005, 17'h02005, 17'h06005, 17'h11234, 17'h09234, 17'h01234,
                  17'h19234, 17'h06010, 17'h06011, 17'h00000, 17'h06FFF, 17'h07FFF};

        // Read during reset: bus is driven but data register is cleared.
        @(negedge CLK);
        A = 15'h2005; CSB = 1'b0; RDB = 1'b0;
        exp_q.push_back(8'h00); name_q.push_back("reset_zero");
        @(negedge CLK);
        RDB = 1'b1; CSB = 1'b1; RESET = 1'b0;
        $display("read  reset_zero     expect 00");

        foreach (addrs[k]) load(addrs[k], romv(addrs[k]), 1'b1);
        load(17'h00000, 8'hEE, 1'b0);

        MAPPER = MAPPER_ROM8K;
        rd("rom8k_mirror", 15'h2005, 8'h05);
        rd("rom8k_mirror3", 15'h6005, 8'h05);
        MAPPER = MAPPER_ROM16K;
        rd("rom16k", 15'h2005, 8'h25);
        rd("rom16k_mirror", 15'h6005, 8'h25);

        MAPPER = MAPPER_ROM128K;
        PC = 2'b10; rd("rom128k_pc10", 15'h1234, 8'h27);
        PC = 2'b01; rd("rom128k_pc01", 15'h1234, 8'hA6);
        PC = 2'b00; rd("rom128k_pc00", 15'h1234, 8'h26);
        PC = 2'b11; rd("rom128k_pc11", 15'h1234, 8'hA7);

        @(negedge CLK);
        A = 15'h1234; CSB = 1'b1; RDB = 1'b0;
        #1;
        checks++;
        if (DB_OE !== 1'b0) begin
            fails++;
            $display("FAIL oe_csb_high: DB_OE=%b expected 0", DB_OE);
        end
        $display("check oe_csb_high    DB_OE=%b expect 0", DB_OE);
        RDB = 1'b1;

        MAPPER = MAPPER_ROM64K;
        PC = 2'b01; rd("rom64k_pc01", 15'h1234, 8'hA6);
        PC = 2'b11; rd("rom64k_pc11", 15'h1234, 8'hA6);

        MAPPER = MAPPER_ROM32K_RAM;
        PC = 2'b01; wr(15'h6010, 8'hA5);
        rd("ram_readback", 15'h6010, 8'hA5);
        PC = 2'b00; rd("ram_disabled", 15'h6010, 8'h70);
        PC = 2'b01; wr(15'h6011, 8'h5A);
        PC = 2'b00; wr(15'h6011, 8'h3C);
        PC = 2'b01; rd("ram_wr_ignored", 15'h6011, 8'h5A);

        // Simultaneous write and read of the same RAM byte returns the old value first.
        @(negedge CLK);
        A = 15'h6010; DB_I = 8'hC3; CSB = 1'b0; WRB = 1'b0; RDB = 1'b0;
        exp_q.push_back(8'hA5); name_q.push_back("ram_read_first");
        @(negedge CLK);
        WRB = 1'b1; RDB = 1'b1; CSB = 1'b1;
        $display("rdwr  ram_read_first A=6010 data C3 expect A5");
        rd("ram_after_rdwr", 15'h6010, 8'hC3);

        MAPPER = MAPPER_ROM128K_RAM;
        PC = 2'b00; wr(15'h7FFF, 8'h77);
        rd("r128ram_rom", 15'h6FFF, 8'h90);
        @(negedge CLK);
        RESET = 1'b1; A = 15'h7FFF; CSB = 1'b0; RDB = 1'b0;
        exp_q.push_back(8'h00); name_q.push_back("reset_clears");
        @(negedge CLK);
        RESET = 1'b0; RDB = 1'b1; CSB = 1'b1;
        $display("read  reset_clears   A=7FFF expect 00");
        rd("ram_survives", 15'h7FFF, 8'h77);

        MAPPER = MAPPER_ROM32K_RAM;
        PC = 2'b01; rd("ram_shared_map", 15'h6FFF, 8'h77);

        MAPPER = MAPPER_ROM32K;
        wr(15'h0000, 8'hFF);
        rd("rom_no_write", 15'h0000, 8'h00);
        MAPPER = mapper_t'(3'd7);
        rd("undef_mapper", 15'h6010, 8'h70);

        repeat (4) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d reads pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
